// File: rtl/tf_gen_ctrl.sv
// Sequencer for the twiddle-factor engine: seeds the limb shift register, issues
// one modular-multiply iteration per limb, and hands each batch downstream via valid/ready.
module tf_gen_ctrl #(
  parameter int LIMBS  = 4,
  parameter int MM_LAT = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       seed_sel,
  input  logic [CNT_W-1:0] num_tf,
  input  logic             clr,
  input  logic             tf_ready,
  output logic             load,
  output logic [1:0]       sel_sr,
  output logic             en,
  output logic             vld,
  output logic             sel_mm,
  output logic             tf_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  localparam int LIMB_W = $clog2(LIMBS + 1);
  localparam int WAIT_W = (MM_LAT > 1) ? $clog2(MM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [LIMB_W-1:0]  limb_cnt_q, limb_cnt_d;
  logic [CNT_W-1:0]   batch_cnt_q, batch_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]         seed_q, seed_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [LIMB_W-1:0]  limb_inc;
  logic [CNT_W-1:0]   batch_inc;

  // tf_valid/tf_ready: a batch transfers in any cycle where both are high;
  // tf_valid stays asserted and the engine idle until that happens.

  assign limb_inc  = limb_cnt_q + LIMB_W'(1);
  assign batch_inc = batch_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    limb_cnt_d  = limb_cnt_q;
    batch_cnt_d = batch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    seed_d      = seed_q;
    num_d       = num_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d  = seed_sel;
          num_d   = num_tf;
          state_d = (num_tf == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        limb_cnt_d  = '0;
        batch_cnt_d = '0;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        limb_cnt_d = limb_inc;
        if (MM_LAT == 1) begin
          state_d = (limb_inc < LIMB_W'(LIMBS)) ? S_ISSUE : S_OUT;
        end else begin
          wait_cnt_d = WAIT_W'(MM_LAT - 1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        if (wait_cnt_q == WAIT_W'(1))
          state_d = (limb_cnt_q < LIMB_W'(LIMBS)) ? S_ISSUE : S_OUT;
      end
      S_OUT: begin
        // LIMBS rotations bring the shift register back to the seed, so no reload.
        if (tf_ready) begin
          batch_cnt_d = batch_inc;
          limb_cnt_d  = '0;
          state_d     = (batch_inc == num_q) ? S_FIN : S_ISSUE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d     = S_IDLE;
      limb_cnt_d  = '0;
      batch_cnt_d = '0;
      wait_cnt_d  = '0;
      seed_d      = seed_q;
      num_d       = num_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      limb_cnt_q  <= '0;
      batch_cnt_q <= '0;
      wait_cnt_q  <= '0;
      seed_q      <= '0;
      num_q       <= '0;
    end else begin
      state_q     <= state_d;
      limb_cnt_q  <= limb_cnt_d;
      batch_cnt_q <= batch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      seed_q      <= seed_d;
      num_q       <= num_d;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load     <= 1'b0;
      sel_sr   <= 2'b00;
      en       <= 1'b0;
      vld      <= 1'b0;
      sel_mm   <= 1'b0;
      tf_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      load     <= (state_d == S_LOAD);
      sel_sr   <= (state_d == S_IDLE) ? 2'b00 : seed_d;
      en       <= (state_d == S_ISSUE);
      vld      <= (state_d == S_ISSUE);
      sel_mm   <= (state_d == S_ISSUE) && (limb_cnt_d != '0);
      tf_valid <= (state_d == S_OUT);
      busy     <= (state_d != S_IDLE);
      done     <= (state_d == S_FIN);
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_tf_gen_ctrl.sv
// Scoreboard bench for tf_gen_ctrl: drivers push expected timestamped events,
// negedge monitors pop and compare each observed load/vld/handshake/done.
module tb_tf_gen_ctrl;

  localparam int LIMBS = 4;
  localparam logic [3:0] K_LOAD = 4'd1, K_VLD = 4'd2, K_HS = 4'd3, K_DONE = 4'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] seed_sel = 2'd0;
  logic [7:0] num_tf = 8'd0;
  logic       clr = 1'b0;
  logic       tf_ready = 1'b1;

  logic       load_a, en_a, vld_a, sel_mm_a, tf_valid_a, busy_a, done_a;
  logic [1:0] sel_sr_a;
  logic [2:0] dbg_a;
  logic       load_b, en_b, vld_b, sel_mm_b, tf_valid_b, busy_b, done_b;
  logic [1:0] sel_sr_b;
  logic [2:0] dbg_b;

  logic [31:0] exp_q[$];
  logic [31:0] exp1_q[$];
  int cyc = 0;
  int vectors = 0;
  int fails = 0;
  logic hold_a = 1'b0, hold_b = 1'b0;

  tf_gen_ctrl #(.LIMBS(4), .MM_LAT(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .seed_sel(seed_sel), .num_tf(num_tf),
    .clr(clr), .tf_ready(tf_ready), .load(load_a), .sel_sr(sel_sr_a), .en(en_a),
    .vld(vld_a), .sel_mm(sel_mm_a), .tf_valid(tf_valid_a), .busy(busy_a),
    .done(done_a), .dbg_state(dbg_a)
  );

  tf_gen_ctrl #(.LIMBS(4), .MM_LAT(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .seed_sel(seed_sel), .num_tf(num_tf),
    .clr(clr), .tf_ready(tf_ready), .load(load_b), .sel_sr(sel_sr_b), .en(en_b),
    .vld(vld_b), .sel_mm(sel_mm_b), .tf_valid(tf_valid_b), .busy(busy_b),
    .done(done_b), .dbg_state(dbg_b)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ev(input logic [3:0] k, input int c, input logic [3:0] d);
    logic [23:0] cc;
    cc = c[23:0];
    return {k, cc, d};
  endfunction

  task automatic push(input int which, input logic [31:0] e);
    if (which == 0) exp_q.push_back(e);
    else exp1_q.push_back(e);
  endtask

  // Expected event model: load at t+1, vld every lat cycles, batch handshake
  // LIMBS*lat after the first vld (plus any stall), next batch starts at h+1.
  task automatic push_run(input int which, input int t, input logic [1:0] seed,
                          input int n, input int lat, input int sb, input int sl);
    int c, h;
    if (n == 0) begin
      push(which, ev(K_DONE, t + 1, 4'd1));
      return;
    end
    push(which, ev(K_LOAD, t + 1, {2'b00, seed}));
    c = t + 2;
    for (int b = 1; b <= n; b++) begin
      for (int k = 0; k < LIMBS; k++)
        push(which, ev(K_VLD, c + k * lat, {3'b011, (k != 0)}));
      h = c + LIMBS * lat + ((b == sb) ? sl : 0);
      push(which, ev(K_HS, h, 4'd0));
      c = h + 1;
    end
    push(which, ev(K_DONE, c, 4'd1));
  endtask

  task automatic check_ev(input int which, input logic [31:0] act, input string name);
    logic [31:0] e;
    vectors++;
    if (which == 0 && exp_q.size() > 0) e = exp_q.pop_front();
    else if (which == 1 && exp1_q.size() > 0) e = exp1_q.pop_front();
    else begin
      fails++;
      $display("FAIL %s: got event %h, none required", name, act);
      return;
    end
    if (e !== act) begin
      fails++;
      $display("FAIL %s: got event %h, required %h", name, act, e);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_a) check_ev(0, ev(K_LOAD, cyc, {2'b00, sel_sr_a}), "a_load");
      if (vld_a || en_a || sel_mm_a) check_ev(0, ev(K_VLD, cyc, {1'b0, vld_a, en_a, sel_mm_a}), "a_vld");
      if (tf_valid_a && tf_ready) check_ev(0, ev(K_HS, cyc, 4'd0), "a_hs");
      if (done_a) check_ev(0, ev(K_DONE, cyc, {3'b000, busy_a}), "a_done");
      if (hold_a) check_val("a_tf_valid_hold", {15'd0, tf_valid_a}, 16'd1);
      hold_a = tf_valid_a && !tf_ready;
    end else hold_a = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (load_b) check_ev(1, ev(K_LOAD, cyc, {2'b00, sel_sr_b}), "b_load");
      if (vld_b || en_b || sel_mm_b) check_ev(1, ev(K_VLD, cyc, {1'b0, vld_b, en_b, sel_mm_b}), "b_vld");
      if (tf_valid_b && tf_ready) check_ev(1, ev(K_HS, cyc, 4'd0), "b_hs");
      if (done_b) check_ev(1, ev(K_DONE, cyc, {3'b000, busy_b}), "b_done");
      if (hold_b) check_val("b_tf_valid_hold", {15'd0, tf_valid_b}, 16'd1);
      hold_b = tf_valid_b && !tf_ready;
    end else hold_b = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one start, optional stall of sl cycles on batch sb
  task automatic run(input int which, input logic [1:0] seed, input int n,
                     input int sb, input int sl);
    int t, lat, per, sv;
    lat = (which == 0) ? 4 : 1;
    per = LIMBS * lat + 1;
    step();
    seed_sel = seed;
    num_tf   = n[7:0];
    if (which == 0) start_a = 1'b1;
    else start_b = 1'b1;
    t = cyc;
    push_run(which, t, seed, n, lat, sb, sl);
    sv = t + 2 + (sb - 1) * per + LIMBS * lat;
    for (int i = 1; i < n * per + sl + 4; i++) begin
      step();
      start_a  = 1'b0;
      start_b  = 1'b0;
      tf_ready = !(sl > 0 && cyc >= sv && cyc < sv + sl);
    end
    tf_ready = 1'b1;
  endtask

  task automatic outs_a(output logic [15:0] v);
    v = {6'd0, load_a, sel_sr_a, en_a, vld_a, sel_mm_a, tf_valid_a, busy_a, done_a, 1'b0};
  endtask

  initial begin
    int t;
    logic [15:0] v;
    // reset
    repeat (3) @(posedge clk);
    #1;
    outs_a(v);
    check_val("reset_outputs", v, 16'd0);
    rst_n = 1'b1;
    step();

    // single batch, defaults
    run(0, 2'd2, 1, 0, 0);

    // backpressure: three batches, batch 2 stalled 5 cycles
    run(0, 2'd1, 3, 2, 5);

    // num_tf = 0
    run(0, 2'd3, 0, 0, 0);

    // abort during second ISSUE, with a start pulsed while busy
    step();
    seed_sel = 2'd2; num_tf = 8'd2; start_a = 1'b1;
    t = cyc;
    push(0, ev(K_LOAD, t + 1, 4'd2));
    push(0, ev(K_VLD, t + 2, 4'b0110));
    push(0, ev(K_VLD, t + 6, 4'b0111));
    for (int i = 1; i <= 6; i++) begin
      step();
      start_a = (i == 3);
      if (i == 3) begin seed_sel = 2'd3; num_tf = 8'd5; end
      clr = (i == 6);
    end
    step();
    clr = 1'b0;
    outs_a(v);
    check_val("abort_idle", v, 16'd0);
    repeat (4) step();
    run(0, 2'd1, 1, 0, 0);

    // async reset mid-WAIT
    step();
    seed_sel = 2'd1; num_tf = 8'd1; start_a = 1'b1;
    t = cyc;
    push(0, ev(K_LOAD, t + 1, 4'd1));
    push(0, ev(K_VLD, t + 2, 4'b0110));
    for (int i = 1; i <= 4; i++) begin
      step();
      start_a = 1'b0;
    end
    check_val("pre_reset_state", {13'd0, dbg_a}, 16'd3);
    rst_n = 1'b0;
    #1;
    outs_a(v);
    check_val("async_reset_outputs", v, 16'd0);
    step();
    rst_n = 1'b1;
    repeat (20) step();
    outs_a(v);
    check_val("post_reset_quiet", v, 16'd0);

    // MM_LAT = 1 instance
    run(1, 2'd0, 1, 0, 0);

    repeat (5) step();
    if (exp_q.size() > 0 || exp1_q.size() > 0) begin
      vectors++;
      fails++;
      $display("FAIL leftover_events: got %0d/%0d unconsumed, required 0/0", exp_q.size(), exp1_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/tf_gen_ctrl.md
# tf_gen_ctrl

Sequencer that drives the twiddle-factor generation engine of the 2D-array twiddle generator. It loads the selected seed into the engine's 64-bit-limb shift register and issues one modular-multiply iteration per limb. It waits the multiplier latency after each iteration, then presents each finished twiddle batch to the downstream consumer through a valid/ready handshake. It repeats this for a programmed number of batches.

## Interface
Parameters:
- LIMBS, 4: 64-bit limbs per 256-bit operand; iterations per batch.
- MM_LAT, 4: cycles from a `vld` pulse until the multiplier result is usable (≥1).
- CNT_W, 8: width of batch count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; accepted only in IDLE.
- seed_sel  in  2  seed index; latched when start is accepted.
- num_tf  in  CNT_W  batches to generate; latched when start is accepted.
- clr  in  1  synchronous abort; returns to IDLE next cycle.
- tf_ready  in  1  downstream accepts the current batch.
- load  out  1  engine shift-register preset strobe.
- sel_sr  out  2  engine seed mux select.
- en  out  1  engine shift-register rotate enable.
- vld  out  1  multiplier iteration strobe.
- sel_mm  out  1  0 = first iteration of batch (fresh accumulate), 1 = continue.
- tf_valid  out  1  batch result available on engine outputs.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last batch handshake.

## Operation
- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE, and the counters reset to 0.
- IDLE: start=1 and clr=0 latches seed_sel and num_tf.
  - If num_tf=0: go to FIN.
  - Otherwise: go to LOAD.
- LOAD (1 cycle):
  - load=1.
  - sel_sr=latched seed_sel; sel_sr holds this value until IDLE.
  - Clear limb_cnt and batch_cnt.
  - Go to ISSUE.
- ISSUE (1 cycle):
  - vld=1, en=1.
  - sel_mm=(limb_cnt!=0).
  - limb_cnt++.
  - Go to WAIT with wait_cnt=MM_LAT-1. If MM_LAT=1, skip WAIT.
- WAIT:
  - Decrement wait_cnt.
  - At 0: if limb_cnt<LIMBS, go to ISSUE; otherwise go to OUT.
- OUT:
  - Hold tf_valid=1 until tf_ready=1.
  - On handshake: batch_cnt++, limb_cnt=0.
  - If batch_cnt+1==num_tf, go to FIN; otherwise go to ISSUE.
  - No reload between batches: LIMBS rotations restore the shift register.
- FIN (1 cycle): done=1, then go to IDLE.
- start while busy is ignored; no queuing.
- clr has priority over every transition:
  - Next cycle: IDLE, all strobes 0, counters 0.
  - clr in IDLE has no effect.
- Asynchronous reset mid-operation forces IDLE immediately. Any partial batch is discarded, and no done pulse is produced.
- sel_mm, vld and en change only on ISSUE cycles. Outside ISSUE: vld=0, en=0, sel_mm=0.

## Timing
- Accepted start at edge t:
  - load high in cycle t+1.
  - First vld in t+2.
  - vld pulses at t+2+k·MM_LAT for k=0..LIMBS-1.
  - tf_valid rises at t+2+LIMBS·MM_LAT.
- Defaults (LIMBS=4, MM_LAT=4): load at t+1; vld at t+2, t+6, t+10, t+14; tf_valid at t+18.
- Handshake in cycle h:
  - tf_valid drops at h+1.
  - The next batch's first vld is at h+1.
  - Its tf_valid rises at h+1+LIMBS·MM_LAT.
- After the last handshake in cycle h: done=1 at h+1, busy=0 at h+2.
- num_tf=0: busy=1 and done=1 at t+1, busy=0 at t+2. No load or vld is issued.
- tf_ready held high throughout gives no backpressure; batch period = LIMBS·MM_LAT+1 cycles.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-WAIT, then release.
  - Required: all outputs 0 immediately; after release, no activity until start.
- Single batch with defaults:
  - Stimulus: start with seed_sel=2, num_tf=1, tf_ready=1.
  - Required: load at t+1 with sel_sr=2; vld at t+2/6/10/14 with sel_mm=0,1,1,1; tf_valid at t+18 for 1 cycle; done at t+19.
- Backpressure:
  - Stimulus: num_tf=3, tf_ready low for 5 cycles on batch 2.
  - Required: tf_valid held steady, no vld issued while stalled, exactly 3 handshakes, then one done pulse.
- num_tf=0:
  - Stimulus: start.
  - Required: done at t+1; load, vld and en never asserted.
- Abort and ignored start:
  - Stimulus: clr during the second ISSUE; start pulsed while busy.
  - Required: IDLE next cycle with no done pulse; the busy start is ignored; a subsequent start runs normally.
- MM_LAT=1:
  - Stimulus: run one batch.
  - Required: vld high on 4 consecutive cycles t+2..t+5; tf_valid at t+6.
